// File: rtl/axi4_write_burst_gen_pkg.sv
// axi4_write_burst_gen_pkg: shared types, constants and burst sizing for the write burst engine
//   state_t        : engine FSM states
//   AXI_BURST_INCR : AXI burst encoding for incrementing bursts
//   BOUNDARY_4K    : AXI bursts may not cross this byte boundary
//   burst_len()    : beats in the next burst, limited by remaining, max burst and 4 KB room
package axi4_write_burst_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_AW,
        S_W,
        S_WAIT_B,
        S_DONE
    } state_t;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [31:0] BOUNDARY_4K    = 32'd4096;

    // addr_lo must be n-aligned, so room is always at least one beat
    function automatic logic [8:0] burst_len(
        input logic [11:0] addr_lo,
        input logic [31:0] remaining,
        input logic [31:0] max_burst,
        input logic [31:0] n
    );
        logic [31:0] room;
        logic [31:0] len;
        room = (BOUNDARY_4K - {20'd0, addr_lo}) / n;
        len  = remaining < max_burst ? remaining : max_burst;
        len  = room < len ? room : len;
        return len[8:0];
    endfunction

endpackage

// File: rtl/axi4_if.sv
// axi4_if: fifo-side AXI4 write channel fields shared between the burst engine and the write FIFOs
//   master modport: drives aw*/w* fields, reads bid/bresp
interface axi4_if #(
    parameter int A = 32,
    parameter int N = 4,
    parameter int I = 1
);
    logic [A-1:0]   awaddr;
    logic [7:0]     awlen;
    logic [2:0]     awsize;
    logic [1:0]     awburst;
    logic [I-1:0]   awid;
    logic [8*N-1:0] wdata;
    logic [N-1:0]   wstrb;
    logic [I-1:0]   wid;
    logic           wlast;
    logic [I-1:0]   bid;
    logic [1:0]     bresp;

    modport master (
        output awaddr, awlen, awsize, awburst, awid, wdata, wstrb, wid, wlast,
        input  bid, bresp
    );
endinterface

// File: rtl/axi4_write_burst_gen.sv
// axi4_write_burst_gen: splits linear write commands into 4 KB-safe INCR bursts feeding AXI4 write FIFOs
//   aclk/aresetn              : clock, asynchronous active-low reset
//   cmd_valid/ready/addr/beats: command handshake (N-aligned start address, beat count, 0 allowed)
//   wr_data_valid/ready/data  : plain data stream, one beat per handshake
//   axi4_write_fifo           : AW/W fields to the FIFOs, B fields from the B FIFO
//   aw_wr_full/en, w_wr_full/en, b_rd_empty/en : FIFO push/pop controls
//   busy/done/err             : command in progress, completion pulse, any SLVERR/DECERR seen
module axi4_write_burst_gen
    import axi4_write_burst_gen_pkg::*;
#(
    parameter int A               = 32,
    parameter int N               = 4,
    parameter int I               = 1,
    parameter int ID              = 0,
    parameter int L               = 16,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [A-1:0]   cmd_addr,
    input  logic [L-1:0]   cmd_beats,
    input  logic           wr_data_valid,
    output logic           wr_data_ready,
    input  logic [8*N-1:0] wr_data,
    axi4_if.master         axi4_write_fifo,
    input  logic           aw_wr_full,
    output logic           aw_wr_en,
    input  logic           w_wr_full,
    output logic           w_wr_en,
    input  logic           b_rd_empty,
    output logic           b_rd_en,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int SZ = $clog2(N);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    state_t         state;
    logic [A-1:0]   addr;
    logic [L-1:0]   remaining;
    logic [L-1:0]   beat;
    logic [8:0]     len;
    logic [OW-1:0]  out_cnt;
    logic           err_acc;
    logic           wlast;
    logic           unused;

    assign wlast         = beat == L'(len) - L'(1);
    assign aw_wr_en      = state == S_AW && !aw_wr_full && out_cnt < OW'(MAX_OUTSTANDING);
    assign w_wr_en       = state == S_W && wr_data_valid && !w_wr_full;
    assign wr_data_ready = w_wr_en;
    // B draining is state-independent; gated by reset so nothing is popped while held in reset
    assign b_rd_en       = aresetn && !b_rd_empty;

    assign axi4_write_fifo.awaddr  = addr;
    assign axi4_write_fifo.awlen   = 8'(len - 9'd1);
    assign axi4_write_fifo.awsize  = 3'(SZ);
    assign axi4_write_fifo.awburst = AXI_BURST_INCR;
    assign axi4_write_fifo.awid    = I'(ID);
    assign axi4_write_fifo.wdata   = wr_data;
    assign axi4_write_fifo.wstrb   = '1;
    assign axi4_write_fifo.wid     = I'(ID);
    assign axi4_write_fifo.wlast   = wlast;
    assign unused = ^{axi4_write_fifo.bid, axi4_write_fifo.bresp[0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            beat      <= '0;
            len       <= '0;
            out_cnt   <= '0;
            err_acc   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            out_cnt <= aw_wr_en && !b_rd_en ? out_cnt + OW'(1) :
                       b_rd_en && !aw_wr_en ? out_cnt - OW'(1) : out_cnt;
            if (b_rd_en)
                err_acc <= err_acc | axi4_write_fifo.bresp[1];
            case (state)
                S_IDLE: if (cmd_valid) begin
                    addr      <= cmd_addr;
                    remaining <= cmd_beats;
                    err_acc   <= 1'b0;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    state     <= cmd_beats == '0 ? S_DONE : S_CALC;
                end
                S_CALC: begin
                    len   <= burst_len(addr[11:0], 32'(remaining), 32'(MAX_BURST), 32'(N));
                    state <= S_AW;
                end
                S_AW: if (aw_wr_en) begin
                    beat  <= '0;
                    state <= S_W;
                end
                S_W: if (w_wr_en) begin
                    beat <= beat + L'(1);
                    if (wlast) begin
                        addr      <= addr + (A'(len) << SZ);
                        remaining <= remaining - L'(len);
                        state     <= remaining == L'(len) ? S_WAIT_B : S_CALC;
                    end
                end
                S_WAIT_B: if (out_cnt == '0) state <= S_DONE;
                S_DONE: begin
                    done      <= 1'b1;
                    err       <= err_acc;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // a B pop with nothing outstanding means the FIFO side returned a response we never requested
    assert property (@(posedge aclk) disable iff (!aresetn) b_rd_en |-> out_cnt != '0);

endmodule

// File: tb/tb_axi4_write_burst_gen.sv
// tb_axi4_write_burst_gen: scoreboard bench for axi4_write_burst_gen with modelled AW/W/B FIFOs
module tb_axi4_write_burst_gen;

    localparam int MO = 2;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } w_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_beats = '0;
    logic        wr_data_valid = 1'b0;
    logic        wr_data_ready;
    logic [31:0] wr_data = '0;
    logic        aw_wr_full = 1'b0;
    logic        aw_wr_en;
    logic        w_wr_full = 1'b0;
    logic        w_wr_en;
    logic        b_rd_empty = 1'b1;
    logic        b_rd_en;
    logic        busy;
    logic        done;
    logic        err;

    axi4_if #(.A(32), .N(4), .I(1)) fifo_if ();

    axi4_write_burst_gen #(
        .A(32), .N(4), .I(1), .ID(0), .L(16), .MAX_BURST(16), .MAX_OUTSTANDING(MO)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_beats(cmd_beats),
        .wr_data_valid(wr_data_valid),
        .wr_data_ready(wr_data_ready),
        .wr_data(wr_data),
        .axi4_write_fifo(fifo_if),
        .aw_wr_full(aw_wr_full),
        .aw_wr_en(aw_wr_en),
        .w_wr_full(w_wr_full),
        .w_wr_en(w_wr_en),
        .b_rd_empty(b_rd_empty),
        .b_rd_en(b_rd_en),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 aclk = ~aclk;

    aw_t         exp_aw[$];
    w_t          exp_w[$];
    logic [31:0] src_q[$];
    logic [1:0]  bq[$];
    logic [1:0]  resp_plan[$];
    logic        exp_done[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int first_aw_cyc = -1;
    int first_w_cyc = -1;
    int aws_cmd = 0;
    int ws_cmd = 0;
    int aw_total = 0;
    int wl_total = 0;
    int tb_out = 0;
    int aw_hold = 0;
    bit gap = 0;
    bit w_tog = 0;
    bit b_hold = 0;
    aw_t ea;
    w_t  ew;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO-side stimulus: data source, full flags, B FIFO contents
    always @(posedge aclk) begin
        cyc++;
        #1;
        wr_data_valid = src_q.size() > 0 && (!gap || $urandom_range(0, 2) != 0);
        wr_data = src_q.size() > 0 ? src_q[0] : 32'h0;
        w_wr_full = w_tog ? !w_wr_full : 1'b0;
        aw_wr_full = aw_hold > 0;
        if (aw_hold > 0) aw_hold--;
        b_rd_empty = b_hold || bq.size() == 0;
        fifo_if.bresp = bq.size() > 0 ? bq[0] : 2'b00;
    end

    // monitor: pops the scoreboard on each FIFO push/pop and on done
    always @(negedge aclk) if (aresetn) begin
        if (aw_wr_en) begin
            check("aw_outstanding", 64'(tb_out < MO), 64'd1);
            check("aw_while_full", 64'(aw_wr_full), 64'd0);
            if (exp_aw.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
            else begin
                ea = exp_aw.pop_front();
                check("awaddr", 64'(fifo_if.awaddr), 64'(ea.addr));
                check("awlen", 64'(fifo_if.awlen), 64'(ea.len));
            end
            check("awsize", 64'(fifo_if.awsize), 64'd2);
            check("awburst", 64'(fifo_if.awburst), 64'd1);
            check("awid", 64'(fifo_if.awid), 64'd0);
            if (first_aw_cyc < 0) first_aw_cyc = cyc;
            aws_cmd++;
            aw_total++;
            tb_out++;
            bq.push_back(resp_plan.size() > 0 ? resp_plan.pop_front() : 2'b00);
        end
        if (w_wr_en || wr_data_ready) check("wr_data_ready", 64'(wr_data_ready), 64'(w_wr_en));
        if (w_wr_en) begin
            check("w_after_aw", 64'(aw_total > wl_total), 64'd1);
            if (exp_w.size() == 0) check("w_unexpected", 64'd1, 64'd0);
            else begin
                ew = exp_w.pop_front();
                check("wdata", 64'(fifo_if.wdata), 64'(ew.data));
                check("wlast", 64'(fifo_if.wlast), 64'(ew.last));
            end
            check("wstrb", 64'(fifo_if.wstrb), 64'hF);
            check("wid", 64'(fifo_if.wid), 64'd0);
            if (first_w_cyc < 0) first_w_cyc = cyc;
            if (fifo_if.wlast) wl_total++;
            ws_cmd++;
            void'(src_q.pop_front());
        end
        if (b_rd_en) begin
            if (bq.size() > 0) void'(bq.pop_front());
            tb_out--;
        end
        if (done) begin
            if (exp_done.size() == 0) check("done_unexpected", 64'd1, 64'd0);
            else check("done_err", 64'(err), 64'(exp_done.pop_front()));
        end
    end

    // independent burst model: min(remaining, 16, room to 4 KB) with 4-byte beats
    task automatic send_cmd(input logic [31:0] a0, input int beats, input logic e);
        logic [31:0] a;
        logic [31:0] d;
        int r;
        int l;
        int room;
        a = a0;
        r = beats;
        while (r > 0) begin
            room = (4096 - int'(a[11:0])) / 4;
            l = r < 16 ? r : 16;
            if (room < l) l = room;
            exp_aw.push_back('{a, 8'(l - 1)});
            for (int k = 0; k < l; k++) begin
                d = $urandom;
                src_q.push_back(d);
                exp_w.push_back('{d, k == l - 1});
            end
            a += 32'(l * 4);
            r -= l;
        end
        exp_done.push_back(e);
        first_aw_cyc = -1;
        first_w_cyc = -1;
        aws_cmd = 0;
        ws_cmd = 0;
        cmd_addr = a0;
        cmd_beats = 16'(beats);
        cmd_valid = 1'b1;
        for (int i = 0; i < 500 && !cmd_ready; i++) @(negedge aclk);
        if (!cmd_ready) check("cmd_accept_timeout", 64'd0, 64'd1);
        @(posedge aclk);
        #1;
        acc_cyc = cyc - 1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && exp_done.size() > 0; i++) @(negedge aclk);
        check({tag, "_done_seen"}, 64'(exp_done.size()), 64'd0);
        check({tag, "_aw_drained"}, 64'(exp_aw.size()), 64'd0);
        check({tag, "_w_drained"}, 64'(exp_w.size()), 64'd0);
        @(negedge aclk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_aw_wr_en"}, 64'(aw_wr_en), 64'd0);
        check({tag, "_w_wr_en"}, 64'(w_wr_en), 64'd0);
        check({tag, "_wr_data_ready"}, 64'(wr_data_ready), 64'd0);
        check({tag, "_b_rd_en"}, 64'(b_rd_en), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int aw_before;
        fifo_if.bid = '0;
        fifo_if.bresp = 2'b00;
        repeat (3) @(posedge aclk);
        #2;
        check_reset_outputs("por");
        aresetn = 1'b1;
        @(negedge aclk);

        send_cmd(32'h0000_1000, 8, 1'b0);
        repeat (4) @(negedge aclk);
        check("lat_aw", 64'(first_aw_cyc - acc_cyc), 64'd2);
        check("lat_w", 64'(first_w_cyc - acc_cyc), 64'd3);
        check("busy_mid", 64'(busy), 64'd1);
        wait_done("t1");

        send_cmd(32'h0000_0000, 40, 1'b0);
        wait_done("t2");
        check("t2_aws", 64'(aws_cmd), 64'd3);
        check("t2_beats", 64'(ws_cmd), 64'd40);

        send_cmd(32'h0000_0FF0, 8, 1'b0);
        wait_done("t3");
        check("t3_aws", 64'(aws_cmd), 64'd2);

        aw_hold = 10;
        w_tog = 1;
        gap = 1;
        send_cmd(32'h0000_2000, 20, 1'b0);
        wait_done("t4a");
        check("t4a_beats", 64'(ws_cmd), 64'd20);
        w_tog = 0;
        gap = 0;

        b_hold = 1;
        send_cmd(32'h0000_3000, 48, 1'b0);
        repeat (80) @(negedge aclk);
        check("t4b_aw_stall", 64'(aws_cmd), 64'(MO));
        check("t4b_busy", 64'(busy), 64'd1);
        b_hold = 0;
        wait_done("t4b");
        check("t4b_aws", 64'(aws_cmd), 64'd3);

        resp_plan.push_back(2'b00);
        resp_plan.push_back(2'b10);
        resp_plan.push_back(2'b00);
        send_cmd(32'h0000_4000, 48, 1'b1);
        wait_done("t5");

        aw_before = aw_total;
        send_cmd(32'h0000_5000, 0, 1'b0);
        @(negedge aclk);
        check("zero_done_early", 64'(done), 64'd0);
        @(negedge aclk);
        check("zero_done", 64'(done), 64'd1);
        check("zero_err", 64'(err), 64'd0);
        check("zero_no_aw", 64'(aw_total - aw_before), 64'd0);
        wait_done("t5z");

        send_cmd(32'h0000_6000, 32, 1'b0);
        for (int i = 0; i < 200 && ws_cmd < 3; i++) @(negedge aclk);
        check("t6_in_burst", 64'(ws_cmd >= 3), 64'd1);
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_aw.delete();
        exp_w.delete();
        src_q.delete();
        bq.delete();
        resp_plan.delete();
        exp_done.delete();
        tb_out = 0;
        aw_total = 0;
        wl_total = 0;
        repeat (2) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        send_cmd(32'h0000_7000, 4, 1'b0);
        wait_done("t6");
        check("t6_beats", 64'(ws_cmd), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_write_burst_gen.md
Name: axi4_write_burst_gen

Overview:
Write-master engine that sits directly upstream of the AXI4 master write-FIFO bridge. It accepts a linear write command (start address, beat count) and a plain data stream. It splits the command into legal INCR bursts and pushes AW entries and W beats into the write FIFOs through the fifo-side axi4_if. It drains B responses from the B FIFO and reports one done/err result per command.

Parameters:
A, 32, address width in bits
N, 4, data bus width in bytes (power of 2, 1..128)
I, 1, ID width
ID, 0, constant value driven on awid/wid
L, 16, width of cmd_beats
MAX_BURST, 16, maximum beats per burst (1..256)
MAX_OUTSTANDING, 4, maximum bursts with AW pushed and B not yet received

Ports:
aclk  input  1  clock
aresetn  input  1  reset. Asynchronous assert, active-low.
cmd_valid  input  1  command request
cmd_ready  output  1  command accept
cmd_addr  input  A  start byte address; must be N-aligned
cmd_beats  input  L  total beats; 0 is legal
wr_data_valid  input  1  data beat available
wr_data_ready  output  1  data beat consumed
wr_data  input  8*N  data beat
axi4_write_fifo  interface  axi4_if(A,N,I)  drives aw*/w* fields; reads bid/bresp
aw_wr_full  input  1  AW FIFO full
aw_wr_en  output  1  AW FIFO push
w_wr_full  input  1  W FIFO full
w_wr_en  output  1  W FIFO push
b_rd_empty  input  1  B FIFO empty
b_rd_en  output  1  B FIFO pop
busy  output  1  command in progress
done  output  1  one-cycle pulse; command fully acknowledged
err  output  1  valid with done; 1 if any bresp[1] was set

Behaviour:
- State machine: IDLE, CALC, AW, W, WAIT_B, DONE.
- Reset state: IDLE, all counters 0. Output reset values: aw_wr_en=0, w_wr_en=0, wr_data_ready=0, b_rd_en=0, busy=0, done=0, err=0, cmd_ready=1.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready, register addr, remaining=cmd_beats, clear err_acc.
  - If cmd_beats=0: go to DONE.
  - Otherwise: go to CALC.
- CALC (one cycle): compute len as the minimum of:
  - remaining
  - MAX_BURST
  - (4096 - addr[11:0]) / N, so a burst never crosses a 4 KB boundary.
  Then go to AW.
- AW: aw_wr_en = ~aw_wr_full & (out_cnt < MAX_OUTSTANDING). AW fields driven for that cycle:
  - awaddr = addr
  - awlen = len-1
  - awsize = log2(N)
  - awburst = 2'b01 (INCR)
  - awid = ID
  On push, go to W with beat=0.
- W: wr_data_ready = w_wr_en = wr_data_valid & ~w_wr_full. W fields driven:
  - wdata = wr_data
  - wstrb = all ones
  - wid = ID
  - wlast = (beat == len-1)
  On each push, beat increments. On the push with wlast:
  - addr += len*N, remaining -= len
  - if remaining=0, go to WAIT_B; else go to CALC.
- Ordering: AW of burst k is always pushed before any W beat of burst k. No W beat is pushed outside W state.
- B handling is independent of state: b_rd_en = ~b_rd_empty, always draining.
  - On pop, err_acc |= bresp[1]. bid is ignored.
- out_cnt:
  - +1 on aw_wr_en, -1 on b_rd_en; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING; never underflows. A pop at out_cnt=0 is a protocol error and is flagged by an assertion.
- WAIT_B: when out_cnt=0, go to DONE.
- DONE (one cycle): done=1, err=err_acc, then go to IDLE.
  - Zero-beat command: done asserts two cycles after accept, err=0.
- busy=1 in every state except IDLE.
- Reset asserted mid-command: all state is abandoned immediately. Entries already pushed into the FIFOs are the system's responsibility.
- Width rules:
  - remaining and beat counters are L bits; len is 9 bits.
  - Address arithmetic is modulo 2^A.
- Minimum latency with no backpressure: accept at T, aw_wr_en at T+2, first w_wr_en at T+3, one W beat per cycle thereafter.

Decomposition:
- Package axi4_write_burst_gen_pkg holds:
  - state enum
  - AXI_BURST_INCR constant
  - BOUNDARY_4K constant
  - pure function burst_len(addr, remaining, max_burst, n) for reuse by a future read engine
- No sub-module; the block is a single FSM plus counters.

Test Plan:
1. N=4, addr 0x1000, beats 8, no backpressure -> one AW (awaddr 0x1000, awlen 7, awsize 2, awburst 1); 8 W beats, wstrb 4'hF, wlast on beat 8; after OKAY B -> done with err=0.
2. addr 0x0000, beats 40, MAX_BURST 16 -> AWs 0x0000/len15, 0x0040/len15, 0x0080/len7; exactly 40 W beats with 3 wlasts.
3. addr 0x0FF0, beats 8 -> AW 0x0FF0/len3, then AW 0x1000/len3; no burst crosses 4 KB.
4. Hold aw_wr_full for 10 cycles, toggle w_wr_full every cycle, random wr_data_valid gaps; separately MAX_OUTSTANDING=2 with B withheld -> no beat lost or duplicated, data order preserved, third AW stalls until first B is popped.
5. Three bursts with SLVERR (bresp 2'b10) on the 2nd -> done with err=1. Zero-beat command -> done two cycles after accept, no AW pushed, err=0.
6. Assert aresetn low mid-W-burst -> all outputs at reset values asynchronously; after release, cmd_ready=1 and a new 4-beat command completes normally.
